// File: rtl/xy_chan_arb.sv
// Merges X buffered producer lanes onto one registered valid/ready stream, round-robin with burst limit Y.
// Latency: push to yv is 2 cycles minimum; 1 word/cycle sustained. Backpressure: yr=0 holds the output stage, full lanes drop xb.
module xy_chan_arb #(
    parameter int X = 4,
    parameter int W = 2,
    parameter int D = 4,
    parameter int Y = 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [X-1:0]                 xa,
    input  logic [X-1:0][W-1:0]          xc,
    output logic [X-1:0]                 xb,
    input  logic [X-1:0]                 cb,
    output logic [W-1:0]                 yb,
    output logic                         yv,
    input  logic                         yr,
    output logic [$clog2(X)-1:0]         ych,
    output logic [X-1:0][1:0]            st,
    input  logic                         ovf_clr,
    output logic                         foobar
);

    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;
    localparam int XW = $clog2(X);
    localparam int BW = $clog2(Y + 1);

    logic [W-1:0]       r_mem [X][D];
    logic [AW-1:0]      r_wp  [X];
    logic [AW-1:0]      r_rp  [X];
    logic [CW-1:0]      r_cnt [X];
    logic [X-1:0]       r_ovf;
    logic [X-1:0][1:0]  r_st;
    logic               r_foobar;
    logic [W-1:0]       r_yb;
    logic [XW-1:0]      r_ych;
    logic               r_yv;
    logic [XW-1:0]      r_last;
    logic [BW-1:0]      r_burst;

    logic [X-1:0]       w_rdy;
    logic [X-1:0]       w_push;
    logic [X-1:0]       w_pop;
    logic [X-1:0]       w_elig;
    logic [X-1:0]       w_ovf_nxt;
    logic [CW-1:0]      w_cnt_nxt [X];
    logic [X-1:0][1:0]  w_st_nxt;
    logic               w_any;
    logic               w_free;
    logic               w_load;
    logic               w_keep;
    logic [XW-1:0]      w_scan;
    logic [XW-1:0]      w_gnt;
    logic [BW-1:0]      w_burst_nxt;
    logic [W-1:0]       w_head;
    int                 w_cand;

    always_comb begin
        for (int i = 0; i < X; i++) begin
            w_rdy[i]  = (r_cnt[i] != CW'(D));
            w_push[i] = xa[i] && w_rdy[i];
            w_elig[i] = (r_cnt[i] != '0) && cb[i];
        end
    end

    // A burst continues only while it is live (r_burst != 0) and under the limit;
    // otherwise scan upward from last+1, which lands back on last if it is the sole candidate.
    always_comb begin
        w_scan = r_last;
        w_cand = 0;
        for (int k = X; k >= 1; k--) begin
            w_cand = (int'(r_last) + k) % X;
            if (w_elig[w_cand]) w_scan = XW'(w_cand);
        end
        w_keep      = w_elig[r_last] && (r_burst != '0) && (r_burst < BW'(Y));
        w_gnt       = w_keep ? r_last : w_scan;
        w_burst_nxt = (w_gnt == r_last) ? ((r_burst < BW'(Y)) ? r_burst + BW'(1) : r_burst)
                                        : BW'(1);
        w_any       = |w_elig;
        w_free      = !r_yv || yr;
        w_load      = w_free && w_any;
        w_head      = r_mem[w_gnt][r_rp[w_gnt]];
    end

    always_comb begin
        for (int i = 0; i < X; i++) begin
            w_pop[i]     = w_load && (w_gnt == XW'(i));
            w_cnt_nxt[i] = r_cnt[i];
            if (w_push[i] && !w_pop[i])
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            else if (!w_push[i] && w_pop[i])
                w_cnt_nxt[i] = r_cnt[i] - CW'(1);
            // a new overflow beats a simultaneous clear
            w_ovf_nxt[i] = (xa[i] && !w_rdy[i]) || (r_ovf[i] && !ovf_clr);
            if (w_ovf_nxt[i])
                w_st_nxt[i] = 2'b11;
            else if (w_cnt_nxt[i] == CW'(D))
                w_st_nxt[i] = 2'b10;
            else if (w_cnt_nxt[i] != '0)
                w_st_nxt[i] = 2'b01;
            else
                w_st_nxt[i] = 2'b00;
        end
    end

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < X; i++) begin
            if (w_push[i]) r_mem[i][r_wp[i]] <= xc[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            for (int i = 0; i < X; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_ovf    <= '0;
            r_st     <= '0;
            r_foobar <= 1'b0;
            r_yb     <= '0;
            r_ych    <= '0;
            r_yv     <= 1'b0;
            r_last   <= XW'(X - 1);
            r_burst  <= '0;
        end else begin
            for (int i = 0; i < X; i++) begin
                if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
                if (w_pop[i])  r_rp[i] <= r_rp[i] + AW'(1);
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_ovf    <= w_ovf_nxt;
            r_st     <= w_st_nxt;
            r_foobar <= |w_ovf_nxt;
            if (w_free) begin
                r_yv <= w_load;
                if (w_load) begin
                    r_yb    <= w_head;
                    r_ych   <= w_gnt;
                    r_last  <= w_gnt;
                    r_burst <= w_burst_nxt;
                end
            end
        end
    end

    assign xb     = w_rdy;
    assign yb     = r_yb;
    assign yv     = r_yv;
    assign ych    = r_ych;
    assign st     = r_st;
    assign foobar = r_foobar;

endmodule

// File: tb/tb_xy_chan_arb.sv
// Bench for xy_chan_arb: two instances (Y=1, Y=2) share stimulus; a queue-level model feeds a scoreboard
// checked by an independent output monitor, plus directed checks of reset, latency, round-robin order, overflow and masking.
module tb_xy_chan_arb;

    localparam int X = 4;
    localparam int W = 2;
    localparam int D = 4;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 yr;
    logic                 ovf_clr;
    logic [X-1:0]         xa;
    logic [X-1:0]         cb;
    logic [X-1:0][W-1:0]  xc;

    logic [X-1:0]         xb_o     [2];
    logic [W-1:0]         yb_o     [2];
    logic                 yv_o     [2];
    logic [1:0]           ych_o    [2];
    logic [X-1:0][1:0]    st_o     [2];
    logic                 foobar_o [2];

    always #5 clk = ~clk;

    xy_chan_arb #(.X(X), .W(W), .D(D), .Y(1)) u_y1 (
        .clk(clk), .rstb(rstb), .xa(xa), .xc(xc), .xb(xb_o[0]), .cb(cb),
        .yb(yb_o[0]), .yv(yv_o[0]), .yr(yr), .ych(ych_o[0]), .st(st_o[0]),
        .ovf_clr(ovf_clr), .foobar(foobar_o[0])
    );

    xy_chan_arb #(.X(X), .W(W), .D(D), .Y(2)) u_y2 (
        .clk(clk), .rstb(rstb), .xa(xa), .xc(xc), .xb(xb_o[1]), .cb(cb),
        .yb(yb_o[1]), .yv(yv_o[1]), .yr(yr), .ych(ych_o[1]), .st(st_o[1]),
        .ovf_clr(ovf_clr), .foobar(foobar_o[1])
    );

    int checks = 0;
    int errors = 0;

    // reference model state: one word queue per (instance, channel)
    logic [W-1:0] mq [2*X][$];
    int           sb [2][$];
    bit           m_yv    [2];
    int           m_last  [2];
    int           m_burst [2];
    bit           m_ovf   [2][X];
    bit           armed = 1'b0;

    bit           logging = 1'b0;
    bit           masklog = 1'b0;
    int           seq [2][$];
    int           masked_hits = 0;

    int               sz [X];
    bit               el [X];
    bit               anyel;
    bit               setv;
    int               g;
    logic [X-1:0]     e_xb;
    logic [X-1:0][1:0] e_st;
    logic [13:0]      expv;
    logic [13:0]      gotv;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: at each negedge compare DUT state with the model, then advance the model by
    // the edge that is about to happen using the inputs now stable on the bus.
    always @(negedge clk) begin
        if (armed) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < X; c++) begin
                    e_xb[c] = (mq[m*X+c].size() < D);
                    if (m_ovf[m][c])               e_st[c] = 2'b11;
                    else if (mq[m*X+c].size() == D) e_st[c] = 2'b10;
                    else if (mq[m*X+c].size() > 0)  e_st[c] = 2'b01;
                    else                            e_st[c] = 2'b00;
                end
                expv = {m_yv[m], e_xb, e_st, (e_st[0] == 2'b11) || (e_st[1] == 2'b11) ||
                                              (e_st[2] == 2'b11) || (e_st[3] == 2'b11)};
                gotv = {yv_o[m], xb_o[m], st_o[m], foobar_o[m]};
                checks++;
                if (gotv !== expv) begin
                    errors++;
                    $display("FAIL state[Y=%0d] {yv,xb,st,foobar} got %h expected %h at %0t",
                             m + 1, gotv, expv, $time);
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (rstb) begin
                for (int c = 0; c < X; c++) begin
                    mq[m*X+c].delete();
                    m_ovf[m][c] = 1'b0;
                end
                sb[m].delete();
                m_yv[m]    = 1'b0;
                m_last[m]  = X - 1;
                m_burst[m] = 0;
            end else begin
                anyel = 1'b0;
                for (int c = 0; c < X; c++) begin
                    sz[c] = mq[m*X+c].size();
                    el[c] = (sz[c] > 0) && cb[c];
                    anyel |= el[c];
                end
                if (!m_yv[m] || yr) begin
                    if (anyel) begin
                        g = m_last[m];
                        if (!(el[m_last[m]] && m_burst[m] > 0 && m_burst[m] < m + 1)) begin
                            for (int k = 1; k <= X; k++) begin
                                if (el[(m_last[m] + k) % X]) begin
                                    g = (m_last[m] + k) % X;
                                    break;
                                end
                            end
                        end
                        if (g != m_last[m]) m_burst[m] = 1;
                        else if (m_burst[m] < m + 1) m_burst[m] = m_burst[m] + 1;
                        m_last[m] = g;
                        sb[m].push_back(g * 256 + int'(mq[m*X+g].pop_front()));
                        m_yv[m] = 1'b1;
                    end else begin
                        m_yv[m] = 1'b0;
                    end
                end
                for (int c = 0; c < X; c++) begin
                    setv = 1'b0;
                    if (xa[c]) begin
                        if (sz[c] < D) mq[m*X+c].push_back(xc[c]);
                        else begin
                            m_ovf[m][c] = 1'b1;
                            setv = 1'b1;
                        end
                    end
                    if (!setv && ovf_clr) m_ovf[m][c] = 1'b0;
                end
            end
        end
        if (rstb) armed = 1'b1;
    end

    // Monitor: every accepted output word must match the head of that instance's scoreboard.
    always @(negedge clk) begin
        if (armed && !rstb) begin
            for (int m = 0; m < 2; m++) begin
                if (yv_o[m] === 1'b1 && yr === 1'b1) begin
                    checks++;
                    if (sb[m].size() == 0) begin
                        errors++;
                        $display("FAIL out[Y=%0d] unexpected word ch %0d data %0d at %0t",
                                 m + 1, ych_o[m], yb_o[m], $time);
                    end else begin
                        g = sb[m].pop_front();
                        if (int'(ych_o[m]) * 256 + int'(yb_o[m]) != g) begin
                            errors++;
                            $display("FAIL out[Y=%0d] got ch %0d data %0d expected ch %0d data %0d at %0t",
                                     m + 1, ych_o[m], yb_o[m], g / 256, g % 256, $time);
                        end
                    end
                    if (logging) seq[m].push_back(int'(ych_o[m]));
                    if (masklog && ych_o[m] == 2'd2) masked_hits++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int exp_seq [2][8];
    bit seq_ok;

    initial begin
        exp_seq[0] = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_seq[1] = '{0, 0, 1, 1, 2, 2, 3, 3};
        rstb = 1'b1; xa = '0; xc = '0; cb = '1; yr = 1'b0; ovf_clr = 1'b0;
        step(); step();
        rstb = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("reset_yv",     int'(yv_o[m]), 0);
            chk("reset_xb",     int'(xb_o[m]), 15);
            chk("reset_st",     int'(st_o[m]), 0);
            chk("reset_foobar", int'(foobar_o[m]), 0);
            chk("reset_yb_ych", int'(yb_o[m]) + int'(ych_o[m]), 0);
        end
        step(); step();

        // single word on ch2: visible after the second edge, gone after the third
        yr = 1'b1; xa = 4'b0100; xc = '0; xc[2] = 2'b10;
        step();
        xa = '0;
        step();
        for (int m = 0; m < 2; m++) begin
            chk("single_yv",  int'(yv_o[m]), 1);
            chk("single_yb",  int'(yb_o[m]), 2);
            chk("single_ych", int'(ych_o[m]), 2);
        end
        step();
        for (int m = 0; m < 2; m++) chk("single_drop_yv", int'(yv_o[m]), 0);

        // round-robin order from a fresh pointer
        rstb = 1'b1; step(); rstb = 1'b0;
        yr = 1'b0; logging = 1'b1; xa = 4'hF;
        xc = X*W'($urandom); step();
        xc = X*W'($urandom); step();
        xa = '0; yr = 1'b1;
        repeat (12) step();
        logging = 1'b0;
        for (int m = 0; m < 2; m++) begin
            seq_ok = (seq[m].size() == 8);
            for (int i = 0; i < 8 && seq_ok; i++) seq_ok = (seq[m][i] == exp_seq[m][i]);
            chk("rr_sequence_ok", int'(seq_ok), 1);
        end

        // backpressure: six words into ch1 (one lands in the output stage, four fill, one overflows)
        yr = 1'b0; xa = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            xc = '0; xc[1] = W'(k);
            step();
        end
        xa = '0;
        step();
        for (int m = 0; m < 2; m++) begin
            chk("full_foobar", int'(foobar_o[m]), 1);
            chk("full_st1",    int'(st_o[m][1]), 3);
            chk("full_hold_yb", int'(yb_o[m]), 0);
        end
        yr = 1'b1;
        repeat (8) step();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("clr_st",     int'(st_o[m]), 0);
            chk("clr_foobar", int'(foobar_o[m]), 0);
        end

        // masked channel is never granted until re-enabled
        cb = 4'b1011; masklog = 1'b1; xa = 4'b0101;
        repeat (3) begin
            xc = X*W'($urandom);
            step();
        end
        xa = '0;
        repeat (6) step();
        masklog = 1'b0;
        chk("mask_ch2_granted", masked_hits, 0);
        cb = 4'hF;
        repeat (6) step();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            xa      = X'($urandom);
            xc      = X*W'($urandom);
            cb      = ($urandom_range(0, 7) == 0) ? X'($urandom) : '1;
            yr      = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        xa = '0; cb = '1; yr = 1'b1; ovf_clr = 1'b0;
        repeat (30) step();

        // reset mid-stream discards everything
        yr = 1'b0; xa = 4'hF;
        repeat (3) begin
            xc = X*W'($urandom);
            step();
        end
        xa = '0; rstb = 1'b1;
        step();
        rstb = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("midreset_yv", int'(yv_o[m]), 0);
            chk("midreset_st", int'(st_o[m]), 0);
        end
        yr = 1'b1;
        repeat (10) step();
        for (int m = 0; m < 2; m++) chk("scoreboard_empty", sb[m].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
